// File: rtl/pipe_csa_addsub_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder/subtractor.
interface pipe_csa_addsub_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             second_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, second_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, second_out, ovf, zero
  );
endinterface

// File: rtl/pipe_csa_addsub.sv
// Pipelined carry-select add/sub: one BLOCK-bit carry-select block resolved per stage,
// whole pipe freezes while the output is stalled.
module pipe_csa_blk #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             cm
);
  // returns {carry into MSB, carry out, sum}
  function automatic logic [BLOCK+1:0] ripple(input logic [BLOCK-1:0] x, input logic [BLOCK-1:0] y,
                                               input logic c0);
    logic             c;
    logic             m;
    logic [BLOCK-1:0] r;
    c = c0;
    m = 1'b0;
    r = '0;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK-1) m = c;
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {m, c, r};
  endfunction

  logic [BLOCK+1:0] r0, r1;
  assign r0 = ripple(a, b, 1'b0);
  assign r1 = ripple(a, b, 1'b1);
  assign {cm, co, s} = ci ? r1 : r0;
endmodule

module pipe_csa_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input logic clk,
  input logic rst,
  pipe_csa_addsub_if.slave io
);
  localparam int STAGES = WIDTH / BLOCK;

  generate
    if ((WIDTH % BLOCK) != 0 || BLOCK < 2) begin : g_bad_cfg
      $error("pipe_csa_addsub: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
    end
  endgenerate

  // index k = state entering stage k; vld_pipe[STAGES] is out_valid
  logic [STAGES:0]                  vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0]     op_a, op_b, sum_q, nxt_sum;
  logic [STAGES-1:0]                cy;
  logic [STAGES-1:0][BLOCK-1:0]     blk_s;
  logic [STAGES-1:0]                blk_co, blk_cm;
  logic [WIDTH-1:0]                 sum_r;
  logic                             cout_r, sec_r, ovf_r, zero_r;
  logic                             stall, en;

  assign stall = vld_pipe[STAGES] & ~io.out_ready;
  assign en    = ~stall;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_csa_blk #(.BLOCK(BLOCK)) u_blk (
        .a  (op_a[k][k*BLOCK +: BLOCK]),
        .b  (op_b[k][k*BLOCK +: BLOCK]),
        .ci (cy[k]),
        .s  (blk_s[k]),
        .co (blk_co[k]),
        .cm (blk_cm[k])
      );
    end
  endgenerate

  always_comb begin
    nxt_sum = sum_q;
    for (int k = 0; k < STAGES; k++) nxt_sum[k][k*BLOCK +: BLOCK] = blk_s[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sum_q    <= '0;
      cy       <= '0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      sec_r    <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (en) begin
      vld_pipe[0] <= io.in_valid;
      op_a[0]     <= io.a;
      op_b[0]     <= io.b ^ {WIDTH{io.sub}};
      cy[0]       <= io.cin ^ io.sub;
      sum_q[0]    <= '0;
      for (int k = 0; k < STAGES-1; k++) begin
        vld_pipe[k+1] <= vld_pipe[k];
        op_a[k+1]     <= op_a[k];
        op_b[k+1]     <= op_b[k];
        sum_q[k+1]    <= nxt_sum[k];
        cy[k+1]       <= blk_co[k];
      end
      vld_pipe[STAGES] <= vld_pipe[STAGES-1];
      // outputs only move when a real result lands, so bubbles never disturb them
      if (vld_pipe[STAGES-1]) begin
        sum_r  <= nxt_sum[STAGES-1];
        cout_r <= blk_co[STAGES-1];
        sec_r  <= blk_cm[STAGES-1];
        ovf_r  <= blk_co[STAGES-1] ^ blk_cm[STAGES-1];
        zero_r <= ~|nxt_sum[STAGES-1];
      end
    end
  end

  // operand bits below the resolved block and lower-block MSB carries are dead by design
  logic unused_ok;
  assign unused_ok = ^{op_a, op_b, blk_cm};

  assign io.in_ready   = ~stall;
  assign io.out_valid  = vld_pipe[STAGES];
  assign io.sum        = sum_r;
  assign io.cout       = cout_r;
  assign io.second_out = sec_r;
  assign io.ovf        = ovf_r;
  assign io.zero       = zero_r;
endmodule

// File: tb/tb_pipe_csa_addsub.sv
// Directed and model-checked bench for pipe_csa_addsub (WIDTH=32, BLOCK=8).
module tb_pipe_csa_addsub;
  localparam int W = 32;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_csa_addsub_if #(.WIDTH(W)) io ();
  pipe_csa_addsub #(.WIDTH(W), .BLOCK(8)) dut (.clk(clk), .rst(rst), .io(io));

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] sum;
    logic         cout, sec, ovf, zero;
  } vec_t;

  typedef struct {
    logic [W+3:0] res;
    int           acc;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // independent arithmetic reference: {sum, cout, second_out, ovf, zero}
  function automatic logic [W+3:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    logic [W-1:0] eb;
    logic         ci;
    logic [W:0]   full;
    logic [W-1:0] low;
    eb   = sub ? ~b : b;
    ci   = cin ^ sub;
    full = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, ci};
    low  = {1'b0, a[W-2:0]} + {1'b0, eb[W-2:0]} + {{(W-1){1'b0}}, ci};
    return {full[W-1:0], full[W], low[W-1], full[W] ^ low[W-1], full[W-1:0] == '0};
  endfunction

  function automatic logic [W+3:0] dut_res();
    return {io.sum, io.cout, io.second_out, io.ovf, io.zero};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input vec_t v);
    int lat;
    io.a = v.a; io.b = v.b; io.cin = v.cin; io.sub = v.sub;
    io.in_valid = 1'b1;
    chk({v.name, "_in_ready"}, {63'd0, io.in_ready}, 64'd1);
    step();
    io.in_valid = 1'b0;
    lat = 0;
    while (!io.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({v.name, "_latency"}, lat, STAGES);
    chk({v.name, "_result"}, dut_res(), {v.sum, v.cout, v.sec, v.ovf, v.zero});
    step();
  endtask

  // stream 8 ops; out_ready dropped on iterations [lo, hi]
  task automatic stream(input string tag, input int lo, input int hi, input bit chk_lat);
    logic [W-1:0] ta[8], tb[8];
    logic         tc[8], ts[8];
    exp_t         q[$];
    exp_t         e;
    int           sent, got;
    logic [W-1:0] prev_sum;
    bit           prev_stall;
    bit           order_ok, lat_ok, hold_ok, rdy_ok;
    for (int i = 0; i < 8; i++) begin
      ta[i] = $urandom; tb[i] = $urandom;
      tc[i] = 1'($urandom_range(0, 1)); ts[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; prev_stall = 0; prev_sum = '0;
    order_ok = 1; lat_ok = 1; hold_ok = 1; rdy_ok = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      io.in_valid = (sent < 8);
      if (sent < 8) begin
        io.a = ta[sent]; io.b = tb[sent]; io.cin = tc[sent]; io.sub = ts[sent];
      end
      io.out_ready = !(cyc >= lo && cyc <= hi);
      #1;
      if (prev_stall && io.out_valid && io.sum !== prev_sum) hold_ok = 0;
      if (io.out_valid && !io.out_ready && io.in_ready) rdy_ok = 0;
      if (io.in_valid && io.in_ready) begin
        q.push_back('{ref_model(ta[sent], tb[sent], tc[sent], ts[sent]), cyc});
        sent++;
      end
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) order_ok = 0;
        else begin
          e = q.pop_front();
          if (dut_res() !== e.res) begin
            order_ok = 0;
            $display("FAIL %s_data%0d: got 0x%0h expected 0x%0h", tag, got, dut_res(), e.res);
          end
          if (cyc != e.acc + STAGES + 1) lat_ok = 0;
        end
        got++;
      end
      prev_stall = io.out_valid && !io.out_ready;
      prev_sum   = io.sum;
      step();
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    chk({tag, "_count"}, got, 8);
    chk({tag, "_order"}, {63'd0, order_ok}, 64'd1);
    if (chk_lat) chk({tag, "_latency"}, {63'd0, lat_ok}, 64'd1);
    else begin
      chk({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
      chk({tag, "_in_ready_low"}, {63'd0, rdy_ok}, 64'd1);
    end
  endtask

  vec_t vecs[9];
  bit   quiet;

  initial begin
    vecs[0] = '{"carry_all", 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 1, 0, 1};
    vecs[1] = '{"pos_ovf",   32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 1, 0};
    vecs[2] = '{"sub_borrow",32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 0};
    vecs[3] = '{"sub_ovf",   32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 0, 1, 0};
    vecs[4] = '{"sub_cin",   32'h0000000A, 32'h00000003, 1, 1, 32'h00000006, 1, 1, 0, 0};
    vecs[5] = '{"add_cin",   32'h12345678, 32'h11111111, 1, 0, 32'h2345678A, 0, 0, 0, 0};
    vecs[6] = '{"sub_eq",    32'h00000005, 32'h00000005, 0, 1, 32'h00000000, 1, 1, 0, 1};
    vecs[7] = '{"blk_edge",  32'h0000FF00, 32'h00000100, 0, 0, 32'h00010000, 0, 0, 0, 0};
    vecs[8] = '{"neg_ovf",   32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 0, 1, 1};

    io.in_valid = 0; io.a = '0; io.b = '0; io.cin = 0; io.sub = 0; io.out_ready = 1;

    // reset held 3 cycles
    rst = 1'b1;
    step(); step(); step();
    chk("reset_outputs", {27'd0, io.out_valid, dut_res()}, 64'd0);
    chk("reset_in_ready", {63'd0, io.in_ready}, 64'd1);
    rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (io.out_valid) quiet = 0;
    end
    chk("idle_after_reset", {63'd0, quiet}, 64'd1);

    foreach (vecs[i]) send_one(vecs[i]);

    stream("stream", 100, 100, 1);
    repeat (8) step();
    stream("bp", 5, 7, 0);
    repeat (8) step();

    // reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      io.a = vecs[i].a; io.b = vecs[i].b; io.cin = vecs[i].cin; io.sub = vecs[i].sub;
      io.in_valid = 1'b1;
      step();
    end
    io.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {27'd0, io.out_valid, dut_res()}, 64'd0);
    step(); step();
    rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (io.out_valid) quiet = 0;
    end
    chk("midrst_no_stale", {63'd0, quiet}, 64'd1);
    send_one(vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
